// File: rtl/fp_mul_mant_norm_if.sv
//------------------------------------------------------------------------------
// Module      : fp_mul_mant_norm_if
// Description : Operand/result handshake bundle for the FP multiply mantissa
//               normalize stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fp_mul_mant_norm_if #(
   parameter int MANT_W = 23,
   parameter int EXP_W  = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic                      sign_a;
   logic                      sign_b;
   logic [MANT_W-1:0]         mant_a;
   logic [MANT_W-1:0]         mant_b;
   logic [EXP_W-1:0]          exp_sum;
   logic                      exp_ovf;
   logic                      exp_unf;
   logic                      op_zero;
   logic                      out_valid;
   logic                      out_ready;
   logic [MANT_W+EXP_W:0]     result;
   logic                      flag_ovf;
   logic                      flag_unf;
   logic                      flag_inexact;

   modport master (
      output in_valid, sign_a, sign_b, mant_a, mant_b, exp_sum,
             exp_ovf, exp_unf, op_zero, out_ready,
      input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inexact
   );

   modport slave (
      input  in_valid, sign_a, sign_b, mant_a, mant_b, exp_sum,
             exp_ovf, exp_unf, op_zero, out_ready,
      output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inexact
   );
endinterface

`default_nettype wire

// File: rtl/fp_mul_mant_norm.sv
//------------------------------------------------------------------------------
// Module      : fp_mul_mant_norm
// Description : Iterative shift-add mantissa multiply, normalize and RNE round
//               for the binary32 multiply path; subnormals flush to zero.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_mul_mant_norm #(
   parameter int MANT_W = 23,
   parameter int EXP_W  = 8
) (
   input  wire logic          CLK,
   input  wire logic          nRST,
   fp_mul_mant_norm_if.slave  bus
);

   localparam int SIG_W  = MANT_W + 1;
   localparam int PROD_W = 2 * SIG_W;
   localparam int CNT_W  = $clog2(SIG_W);
   localparam int SE_W   = EXP_W + 2;
   localparam int RES_W  = 1 + EXP_W + MANT_W;
   localparam int FS_W   = MANT_W + 1;

   localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(SIG_W - 1);
   localparam logic signed [SE_W-1:0]  E_MAX    = SE_W'((1 << EXP_W) - 1);
   localparam logic signed [SE_W-1:0]  E_MIN    = '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  state_q,     state_d;
   logic                    s_q,         s_d;
   logic                    zero_q,      zero_d;
   logic [SIG_W-1:0]        ma_q,        ma_d;
   logic [SIG_W-1:0]        mb_q,        mb_d;
   logic signed [SE_W-1:0]  e0_q,        e0_d;
   logic [PROD_W-1:0]       p_q,         p_d;
   logic [CNT_W-1:0]        cnt_q,       cnt_d;
   logic [RES_W-1:0]        result_q,    result_d;
   logic                    ovf_q,       ovf_d;
   logic                    unf_q,       unf_d;
   logic                    inex_q,      inex_d;
   logic                    out_valid_q, out_valid_d;

   logic                    p_msb;
   logic [MANT_W-1:0]       frac_raw;
   logic                    guard;
   logic                    sticky;
   logic                    round_up;
   logic [FS_W-1:0]         frac_sum;
   logic signed [SE_W-1:0]  e_base;
   logic signed [SE_W-1:0]  e_fin;
   logic [RES_W-1:0]        norm_result;
   logic                    norm_ovf;
   logic                    norm_unf;
   logic                    norm_inex;

   // Normalize/round datapath; only consumed while in NORM.
   always_comb begin
      p_msb = p_q[PROD_W-1];
      if (p_msb) begin
         frac_raw = p_q[PROD_W-2 -: MANT_W];
         guard    = p_q[PROD_W-2-MANT_W];
         sticky   = |p_q[PROD_W-3-MANT_W:0];
         e_base   = e0_q + SE_W'(2);
      end else begin
         frac_raw = p_q[PROD_W-3 -: MANT_W];
         guard    = p_q[PROD_W-3-MANT_W];
         sticky   = |p_q[PROD_W-4-MANT_W:0];
         e_base   = e0_q + SE_W'(1);
      end
      round_up = guard & (sticky | frac_raw[0]);
      frac_sum = {1'b0, frac_raw} + FS_W'(round_up);
      // A carry out leaves the low bits at zero, which is exactly 1.0 x 2^(E+1).
      e_fin    = e_base + SE_W'(frac_sum[MANT_W]);

      norm_result = {s_q, e_fin[EXP_W-1:0], frac_sum[MANT_W-1:0]};
      norm_ovf    = 1'b0;
      norm_unf    = 1'b0;
      norm_inex   = guard | sticky;
      if (zero_q) begin
         norm_result = {s_q, {(EXP_W+MANT_W){1'b0}}};
         norm_inex   = 1'b0;
      end else if (e_fin >= E_MAX) begin
         norm_result = {s_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
         norm_ovf    = 1'b1;
         norm_inex   = 1'b1;
      end else if (e_fin <= E_MIN) begin
         norm_result = {s_q, {(EXP_W+MANT_W){1'b0}}};
         norm_unf    = 1'b1;
         norm_inex   = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      zero_d   = zero_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      e0_d     = e0_q;
      p_d      = p_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      inex_d   = inex_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               s_d    = bus.sign_a ^ bus.sign_b;
               zero_d = bus.op_zero;
               ma_d   = {1'b1, bus.mant_a};
               mb_d   = {1'b1, bus.mant_b};
               if (bus.exp_unf)
                  e0_d = {2'b11, bus.exp_sum};
               else if (bus.exp_ovf)
                  e0_d = {2'b01, bus.exp_sum};
               else
                  e0_d = {2'b00, bus.exp_sum};
               p_d     = '0;
               cnt_d   = '0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            if (mb_q[cnt_q])
               p_d = p_q + ({{SIG_W{1'b0}}, ma_q} << cnt_q);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT)
               state_d = S_NORM;
         end
         S_NORM: begin
            result_d = norm_result;
            ovf_d    = norm_ovf;
            unf_d    = norm_unf;
            inex_d   = norm_inex;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      out_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         s_q         <= 1'b0;
         zero_q      <= 1'b0;
         ma_q        <= '0;
         mb_q        <= '0;
         e0_q        <= '0;
         p_q         <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         inex_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         zero_q      <= zero_d;
         ma_q        <= ma_d;
         mb_q        <= mb_d;
         e0_q        <= e0_d;
         p_q         <= p_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         inex_q      <= inex_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready     = (state_q == S_IDLE);
   assign bus.out_valid    = out_valid_q;
   assign bus.result       = result_q;
   assign bus.flag_ovf     = ovf_q;
   assign bus.flag_unf     = unf_q;
   assign bus.flag_inexact = inex_q;

endmodule

`default_nettype wire
